// File: rtl/mult_div_unit_pkg.sv
// Shared decode constants and FSM state type for the HI/LO multiply/divide unit.
package mult_div_unit_pkg;

   localparam logic [5:0] FUNCT_MFHI  = 6'h10;
   localparam logic [5:0] FUNCT_MTHI  = 6'h11;
   localparam logic [5:0] FUNCT_MFLO  = 6'h12;
   localparam logic [5:0] FUNCT_MTLO  = 6'h13;
   localparam logic [5:0] FUNCT_MULT  = 6'h18;
   localparam logic [5:0] FUNCT_MULTU = 6'h19;
   localparam logic [5:0] FUNCT_DIV   = 6'h1A;
   localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

   localparam logic [4:0] LAST_ITER = 5'd31;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIXUP
   } muldiv_state_t;

endpackage

// File: rtl/mult_div_unit.sv
// Iterative 32-cycle shift-add multiplier / restoring divider owning HI and LO.
module mult_div_unit
   import mult_div_unit_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [5:0]  fncode,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   muldiv_state_t state;
   logic [4:0]    cnt;
   logic [63:0]   acc;
   logic [31:0]   operand;
   logic [31:0]   a_save;
   logic          is_div;
   logic          neg_q;
   logic          neg_r;
   logic          div_zero;

   logic          signed_op;
   logic          muldiv_op;
   logic [31:0]   a_mag;
   logic [31:0]   b_mag;
   logic [32:0]   mul_sum;
   logic [63:0]   mul_step;
   logic [32:0]   div_pr;
   logic [32:0]   div_diff;
   logic [63:0]   div_step;
   logic [63:0]   prod_fix;
   logic [31:0]   quo_fix;
   logic [31:0]   rem_fix;

   assign busy = (state != IDLE);

   always_comb begin
      signed_op = (fncode == FUNCT_MULT) || (fncode == FUNCT_DIV);
      muldiv_op = (fncode == FUNCT_MULT) || (fncode == FUNCT_MULTU) ||
                  (fncode == FUNCT_DIV)  || (fncode == FUNCT_DIVU);
      a_mag = (signed_op && op_a[31]) ? -op_a : op_a;
      b_mag = (signed_op && op_b[31]) ? -op_b : op_b;

      // Multiply: add multiplicand into the upper half when the LSB is set, then shift right.
      mul_sum  = {1'b0, acc[63:32]} + {1'b0, operand};
      mul_step = acc[0] ? {mul_sum, acc[31:1]} : {1'b0, acc[63:1]};

      // Divide: the partial remainder after the left shift needs 33 bits.
      div_pr   = acc[63:31];
      div_diff = div_pr - {1'b0, operand};
      div_step = div_diff[32] ? {div_pr[31:0], acc[30:0], 1'b0}
                              : {div_diff[31:0], acc[30:0], 1'b1};

      prod_fix = neg_q ? -acc : acc;
      quo_fix  = neg_q ? -acc[31:0] : acc[31:0];
      rem_fix  = neg_r ? -acc[63:32] : acc[63:32];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         acc      <= '0;
         operand  <= '0;
         a_save   <= '0;
         is_div   <= 1'b0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         div_zero <= 1'b0;
         done     <= 1'b0;
         hi       <= '0;
         lo       <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (muldiv_op) begin
                     is_div   <= fncode[1];
                     neg_q    <= signed_op && (op_a[31] ^ op_b[31]);
                     neg_r    <= signed_op && op_a[31];
                     div_zero <= (op_b == '0);
                     a_save   <= op_a;
                     // Divide shifts the dividend out of the low half; multiply shifts the multiplier.
                     operand  <= fncode[1] ? b_mag : a_mag;
                     acc      <= {32'b0, fncode[1] ? a_mag : b_mag};
                     cnt      <= '0;
                     state    <= CALC;
                  end else if (fncode == FUNCT_MTHI) begin
                     hi <= op_a;
                  end else if (fncode == FUNCT_MTLO) begin
                     lo <= op_a;
                  end
               end
            end
            CALC: begin
               acc <= is_div ? div_step : mul_step;
               cnt <= cnt + 5'd1;
               if (cnt == LAST_ITER) begin
                  state <= FIXUP;
               end
            end
            FIXUP: begin
               if (!is_div) begin
                  hi <= prod_fix[63:32];
                  lo <= prod_fix[31:0];
               end else if (div_zero) begin
                  hi <= a_save;
                  lo <= '1;
               end else begin
                  hi <= rem_fix;
                  lo <= quo_fix;
               end
               cnt   <= '0;
               done  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit: latency, HI/LO results, MTHI/MTLO and reset abort.
module tb_mult_div_unit;
   import mult_div_unit_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [5:0]  fncode;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   mult_div_unit dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .fncode (fncode),
      .op_a   (op_a),
      .op_b   (op_b),
      .busy   (busy),
      .done   (done),
      .hi     (hi),
      .lo     (lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue a mul/div, count busy cycles, then check done/HI/LO on the cycle busy drops.
   // glitch_at >= 0 re-asserts start with an MTHI request at that busy cycle.
   task automatic run_op(input string tag, input logic [5:0] fn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo, input int glitch_at);
      int cycles;
      fncode = fn; op_a = a; op_b = b; start = 1'b1;
      tick();
      start = 1'b0;
      cycles = 0;
      while (busy && cycles < 100) begin
         check({tag, "_done_early"}, {31'b0, done}, 32'd0);
         if (cycles == glitch_at) begin
            fncode = FUNCT_MTHI; op_a = 32'hDEAD_BEEF; start = 1'b1;
         end
         cycles++;
         tick();
         start = 1'b0;
      end
      check({tag, "_busy_cycles"}, 32'(cycles), 32'd33);
      check({tag, "_done"}, {31'b0, done}, 32'd1);
      check({tag, "_hi"}, hi, exp_hi);
      check({tag, "_lo"}, lo, exp_lo);
      tick();
      check({tag, "_done_drop"}, {31'b0, done}, 32'd0);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; fncode = '0; op_a = '0; op_b = '0;
      tick();
      tick();
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_done", {31'b0, done}, 32'd0);
      check("rst_hi", hi, 32'd0);
      check("rst_lo", lo, 32'd0);
      reset = 1'b0;
      tick();

      run_op("multu_max", FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, -1);
      run_op("mult_neg", FUNCT_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, -1);
      run_op("mult_min", FUNCT_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, -1);
      run_op("div_neg", FUNCT_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, -1);
      run_op("divu_7_2", FUNCT_DIVU, 32'd7, 32'd2, 32'd1, 32'd3, -1);
      run_op("div_zero", FUNCT_DIV, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, -1);
      run_op("div_ovf", FUNCT_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, -1);

      // MTHI / MTLO while idle
      fncode = FUNCT_MTHI; op_a = 32'hCAFE_F00D; start = 1'b1;
      tick();
      start = 1'b0;
      check("mthi_hi", hi, 32'hCAFE_F00D);
      check("mthi_busy", {31'b0, busy}, 32'd0);
      check("mthi_done", {31'b0, done}, 32'd0);
      fncode = FUNCT_MTLO; op_a = 32'h1234_5678; start = 1'b1;
      tick();
      start = 1'b0;
      check("mtlo_lo", lo, 32'h1234_5678);
      check("mtlo_hi_kept", hi, 32'hCAFE_F00D);
      check("mtlo_done", {31'b0, done}, 32'd0);

      // 0x10000 * 0x10001 = 0x1_0001_0000; restart mid-op must be ignored
      run_op("multu_glitch", FUNCT_MULTU, 32'h0001_0000, 32'h0001_0001, 32'h0000_0001, 32'h0001_0000, 5);

      // Reset abort at E10
      fncode = FUNCT_DIVU; op_a = 32'd100; op_b = 32'd3; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 1; i < 10; i++) tick();
      check("abort_busy_pre", {31'b0, busy}, 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abort_busy", {31'b0, busy}, 32'd0);
      check("abort_hi", hi, 32'd0);
      check("abort_lo", lo, 32'd0);
      check("abort_done", {31'b0, done}, 32'd0);
      for (int i = 0; i < 30; i++) begin
         tick();
         check("abort_no_done", {31'b0, done}, 32'd0);
      end
      run_op("divu_100_3", FUNCT_DIVU, 32'd100, 32'd3, 32'd1, 32'd33, -1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
